// File: rtl/qed_dup_sequencer_if.sv
// Fetch-side and decode-side signals of the SQED duplicate sequencer.
// The master drives fetch and control inputs; the slave is the sequencer.
interface qed_dup_sequencer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   ifu_instruction;
  logic          ifu_vld;
  logic          ifu_ready;
  logic          stall;
  logic          exec_dup;
  logic [31:0]   qed_instruction;
  logic          qed_vld;
  logic          qed_ready;
  logic          illegal;
  logic [CW-1:0] fifo_count;

  modport master (
    output ifu_instruction, ifu_vld, stall, exec_dup,
    input  ifu_ready, qed_instruction, qed_vld, qed_ready, illegal, fifo_count
  );

  modport slave (
    input  ifu_instruction, ifu_vld, stall, exec_dup,
    output ifu_ready, qed_instruction, qed_vld, qed_ready, illegal, fifo_count
  );
endinterface

// File: rtl/qed_dup_sequencer.sv
// SQED front end: issues legal originals, queues them, then replays each as a
// duplicate using the upper register half and an offset memory address.
module qed_dup_sequencer #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MEM_OFFSET = 128,
  parameter bit          EN_MUL     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  qed_dup_sequencer_if.slave bus
);
  localparam int unsigned HALF = NUM_REGS / 2;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  typedef enum logic {ORIG, DUP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   qed_instr_q, qed_instr_d;
  logic          qed_vld_q, qed_vld_d;
  logic          qed_ready_q, qed_ready_d;
  logic          illegal_q, illegal_d;
  logic          paired_q, paired_d;
  logic          push, pop;
  logic          ready_c, legal_c, funct_ok;
  logic [31:0]   ins, head, dup_c;
  logic [11:0]   mem_imm;

  function automatic logic reg_ok(input logic [4:0] r);
    return 32'(r) < HALF;
  endfunction

  function automatic logic [4:0] move_reg(input logic [4:0] r);
    return (r == 5'd0) ? r : r + 5'(HALF);
  endfunction

  assign ins     = bus.ifu_instruction;
  assign head    = fifo_mem[rd_ptr_q];
  assign ready_c = (state_q == ORIG) && !bus.stall && (count_q < CW'(DEPTH));

  // Legal SQED subset check on the fetched instruction
  always_comb begin
    legal_c  = 1'b0;
    funct_ok = 1'b0;
    case (ins[6:0])
      OP_R: begin
        case (ins[31:25])
          7'b0000000: funct_ok = 1'b1;
          7'b0100000: funct_ok = (ins[14:12] == 3'b000) || (ins[14:12] == 3'b101);
          7'b0000001: funct_ok = EN_MUL && !ins[14];
          default:    funct_ok = 1'b0;
        endcase
        legal_c = funct_ok && reg_ok(ins[11:7]) && reg_ok(ins[19:15]) && reg_ok(ins[24:20]);
      end
      OP_I: begin
        case (ins[14:12])
          3'b001:  funct_ok = (ins[31:25] == 7'b0000000);
          3'b101:  funct_ok = (ins[31:25] == 7'b0000000) || (ins[31:25] == 7'b0100000);
          default: funct_ok = 1'b1;
        endcase
        legal_c = funct_ok && reg_ok(ins[11:7]) && reg_ok(ins[19:15]);
      end
      OP_LW: legal_c = (ins[14:12] == 3'b010) && (ins[19:15] == 5'd0) &&
                       (ins[31:25] == 7'd0) && reg_ok(ins[11:7]);
      OP_SW: legal_c = (ins[14:12] == 3'b010) && (ins[24:20] == 5'd0) &&
                       (ins[31:25] == 7'd0) && reg_ok(ins[19:15]);
      default: legal_c = 1'b0;
    endcase
  end

  // Duplicate of the FIFO head: registers moved up, memory immediate offset
  always_comb begin
    dup_c   = head;
    mem_imm = 12'd0;
    case (head[6:0])
      OP_R: begin
        dup_c[11:7]  = move_reg(head[11:7]);
        dup_c[19:15] = move_reg(head[19:15]);
        dup_c[24:20] = move_reg(head[24:20]);
      end
      OP_I: begin
        dup_c[11:7]  = move_reg(head[11:7]);
        dup_c[19:15] = move_reg(head[19:15]);
      end
      OP_LW: begin
        mem_imm      = head[31:20] + 12'(MEM_OFFSET);
        dup_c[11:7]  = move_reg(head[11:7]);
        dup_c[31:20] = mem_imm;
      end
      OP_SW: begin
        mem_imm      = {head[31:25], head[11:7]} + 12'(MEM_OFFSET);
        dup_c[19:15] = move_reg(head[19:15]);
        dup_c[31:25] = mem_imm[11:5];
        dup_c[11:7]  = mem_imm[4:0];
      end
      default: dup_c = head;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    qed_instr_d = qed_instr_q;
    qed_vld_d   = 1'b0;
    illegal_d   = illegal_q;
    paired_d    = paired_q;
    push        = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ORIG: begin
        if (bus.ifu_vld && ready_c) begin
          if (legal_c) begin
            push        = 1'b1;
            qed_instr_d = ins;
            qed_vld_d   = 1'b1;
          end else begin
            illegal_d = 1'b1;
          end
        end
        count_d = count_q + CW'(push);
        if ((bus.exec_dup && (count_d != '0)) || (count_d == CW'(DEPTH))) state_d = DUP;
      end
      DUP: begin
        if (!bus.stall) begin
          pop         = 1'b1;
          qed_instr_d = dup_c;
          qed_vld_d   = 1'b1;
          count_d     = count_q - CW'(1);
          if (count_d == '0) begin
            state_d  = ORIG;
            paired_d = 1'b1;
          end
        end
      end
      default: state_d = ORIG;
    endcase
    qed_ready_d = (state_d == ORIG) && (count_d == '0) && paired_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ORIG;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      qed_instr_q <= '0;
      qed_vld_q   <= 1'b0;
      qed_ready_q <= 1'b0;
      illegal_q   <= 1'b0;
      paired_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_q + AW'(push);
      rd_ptr_q    <= rd_ptr_q + AW'(pop);
      count_q     <= count_d;
      qed_instr_q <= qed_instr_d;
      qed_vld_q   <= qed_vld_d;
      qed_ready_q <= qed_ready_d;
      illegal_q   <= illegal_d;
      paired_q    <= paired_d;
    end
  end

  // Storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= ins;
  end

  assign bus.ifu_ready       = ready_c;
  assign bus.qed_instruction = qed_instr_q;
  assign bus.qed_vld         = qed_vld_q;
  assign bus.qed_ready       = qed_ready_q;
  assign bus.illegal         = illegal_q;
  assign bus.fifo_count      = count_q;
endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Scoreboard bench for qed_dup_sequencer: directed originals with hand-encoded
// duplicates; a monitor checks every issued instruction in order.
module tb_qed_dup_sequencer;
  localparam int unsigned DEPTH = 4;

  localparam logic [31:0] ADD_O  = 32'h003100B3, ADD_D  = 32'h013908B3;
  localparam logic [31:0] LW_O   = 32'h00802283, LW_D   = 32'h08802A83;
  localparam logic [31:0] AI1_O  = 32'h00100093, AI1_D  = 32'h00100893;
  localparam logic [31:0] AI2_O  = 32'h00508113, AI2_D  = 32'h00588913;
  localparam logic [31:0] AI3_O  = 32'hFFF10193, AI3_D  = 32'hFFF90993;
  localparam logic [31:0] AI4_O  = 32'h00718213, AI4_D  = 32'h00798A13;
  localparam logic [31:0] SW_O   = 32'h00032223, SW_D   = 32'h080B2223;
  localparam logic [31:0] SRA_O  = 32'h40345393, SRA_D  = 32'h403C5B93;
  localparam logic [31:0] SUB_O  = 32'h40B504B3, SUB_D  = 32'h41BD0CB3;
  localparam logic [31:0] ILL_HI = 32'h002088B3;
  localparam logic [31:0] ILL_MU = 32'h023100B3;
  localparam logic [31:0] ILL_LW = 32'h0080A283;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  qed_dup_sequencer_if #(.DEPTH(DEPTH)) bus ();

  qed_dup_sequencer #(
    .NUM_REGS(32), .DEPTH(DEPTH), .MEM_OFFSET(128), .EN_MUL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
  endtask

  // Monitor: every issued instruction must match the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.qed_vld) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_issue: got 0x%08h, want no issue", bus.qed_instruction);
        end else begin
          chk("issue_order", bus.qed_instruction, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  task automatic send(input logic [31:0] orig, input logic [31:0] dup);
    int waited = 0;
    bus.ifu_instruction = orig;
    bus.ifu_vld = 1'b1;
    while (!bus.ifu_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ifu_ready) begin
      n_checks++;
      $display("FAIL send_timeout: ifu_ready 0, want 1");
    end else begin
      exp_q.push_back(orig);
      pend_q.push_back(dup);
    end
    @(negedge clk);
    bus.ifu_vld = 1'b0;
  endtask

  task automatic flush();
    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
  endtask

  task automatic start_dup();
    bus.exec_dup = 1'b1;
    flush();
    @(negedge clk);
    bus.exec_dup = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || bus.fifo_count != '0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d issues outstanding, want 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic reject(input string name, input logic [31:0] ins);
    bus.ifu_instruction = ins;
    bus.ifu_vld = 1'b1;
    @(negedge clk);
    bus.ifu_vld = 1'b0;
    chk({name, "_vld"}, 32'(bus.qed_vld), 32'd0);
    chk({name, "_count"}, 32'(bus.fifo_count), 32'd0);
    chk({name, "_illegal"}, 32'(bus.illegal), 32'd1);
    chk({name, "_qed_ready"}, 32'(bus.qed_ready), 32'd1);
  endtask

  initial begin
    bus.ifu_instruction = '0;
    bus.ifu_vld  = 1'b0;
    bus.stall    = 1'b0;
    bus.exec_dup = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_qed_vld", 32'(bus.qed_vld), 32'd0);
    chk("rst_qed_instr", bus.qed_instruction, 32'd0);
    chk("rst_qed_ready", 32'(bus.qed_ready), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ifu_ready", 32'(bus.ifu_ready), 32'd1);

    // R-type original then duplicate
    send(ADD_O, ADD_D);
    chk("add_count", 32'(bus.fifo_count), 32'd1);
    chk("add_qed_ready", 32'(bus.qed_ready), 32'd0);
    start_dup();
    drain();
    chk("pair1_qed_ready", 32'(bus.qed_ready), 32'd1);
    chk("pair1_count", 32'(bus.fifo_count), 32'd0);

    // LW with memory offset; qed_ready drops after the accept
    send(LW_O, LW_D);
    chk("lw_qed_ready_drop", 32'(bus.qed_ready), 32'd0);
    start_dup();
    drain();
    chk("pair2_qed_ready", 32'(bus.qed_ready), 32'd1);

    // Full FIFO forces replay; fetch ignored throughout
    send(AI1_O, AI1_D);
    send(AI2_O, AI2_D);
    send(AI3_O, AI3_D);
    send(AI4_O, AI4_D);
    flush();
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("ifu_ready_in_dup", 32'(bus.ifu_ready), 32'd0);
      bus.ifu_instruction = ILL_HI;
      bus.ifu_vld = (i < 3);
      @(negedge clk);
    end
    drain();
    chk("dup_ignores_ifu", 32'(bus.illegal), 32'd0);
    chk("pair3_qed_ready", 32'(bus.qed_ready), 32'd1);

    // Illegal instructions: not queued, sticky flag
    reject("ill_upper_reg", ILL_HI);
    reject("ill_mul", ILL_MU);
    reject("ill_lw_rs1", ILL_LW);
    @(negedge clk);
    chk("illegal_sticky", 32'(bus.illegal), 32'd1);

    // Stall mid-replay holds the FIFO and suppresses issue
    send(SW_O, SW_D);
    send(SRA_O, SRA_D);
    send(SUB_O, SUB_D);
    bus.exec_dup = 1'b1;
    flush();
    @(negedge clk);
    bus.exec_dup = 1'b0;
    @(negedge clk);
    bus.stall = 1'b1;
    chk("stall_start_count", 32'(bus.fifo_count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_qed_vld", 32'(bus.qed_vld), 32'd0);
      chk("stall_count", 32'(bus.fifo_count), 32'd2);
    end
    bus.stall = 1'b0;
    drain();
    chk("pair4_qed_ready", 32'(bus.qed_ready), 32'd1);

    // Asynchronous reset mid-replay discards the queue
    send(ADD_O, ADD_D);
    send(AI1_O, AI1_D);
    send(AI2_O, AI2_D);
    bus.exec_dup = 1'b1;
    exp_q.push_back(pend_q.pop_front());
    pend_q.delete();
    @(negedge clk);
    bus.exec_dup = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 32'(bus.fifo_count), 32'd2);
    chk("pre_rst_vld", 32'(bus.qed_vld), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_qed_vld", 32'(bus.qed_vld), 32'd0);
    chk("arst_qed_instr", bus.qed_instruction, 32'd0);
    chk("arst_qed_ready", 32'(bus.qed_ready), 32'd0);
    chk("arst_illegal", 32'(bus.illegal), 32'd0);
    chk("arst_count", 32'(bus.fifo_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ifu_ready", 32'(bus.ifu_ready), 32'd1);
    chk("post_rst_qed_ready", 32'(bus.qed_ready), 32'd0);
    send(SUB_O, SUB_D);
    start_dup();
    drain();
    chk("pair5_qed_ready", 32'(bus.qed_ready), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
